// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master = control unit side, slave = datapath side.
interface multicycle_control_fsm_if #(
  parameter int STATE_W = 4,
  parameter int OP_W    = 7
);
  logic [OP_W-1:0]    op;
  logic               zero;
  logic               mem_ready;
  logic [1:0]         alu_op;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         result_src;
  logic               adr_src;
  logic               ir_write;
  logic               reg_write;
  logic               mem_write;
  logic               pc_write;
  logic               illegal;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  op, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, result_src,
    output adr_src, ir_write, reg_write, mem_write,
    output pc_write, illegal, state_dbg
  );

  modport slave (
    output op, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, result_src,
    input  adr_src, ir_write, reg_write, mem_write,
    input  pc_write, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM (lw, sw, R, I, beq, jal).
// Optional ILLEGAL_OP_TRAP_EN: unknown opcodes lock into TRAP.
module multicycle_control_fsm #(
  parameter int STATE_W = 4,
  parameter int OP_W    = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    EXECI    = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BEQ      = STATE_W'(9),
    JAL      = STATE_W'(10),
    TRAP     = STATE_W'(11)
  } state_t;

  localparam logic [OP_W-1:0] OP_LW  = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_R   = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_I   = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(7'b1100011);
  localparam logic [OP_W-1:0] OP_JAL = OP_W'(7'b1101111);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_res;
  logic       w_adr;
  logic       w_ir;
  logic       w_rw;
  logic       w_mw;
  logic       w_pw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_alu_op = 2'b00;
    w_src_a  = 2'b00;
    w_src_b  = 2'b00;
    w_res    = 2'b00;
    w_adr    = 1'b0;
    w_ir     = 1'b0;
    w_rw     = 1'b0;
    w_mw     = 1'b0;
    w_pw     = 1'b0;
    case (r_state)
      FETCH: begin
        w_src_b = 2'b10;
        w_res   = 2'b10;
        w_ir    = bus.mem_ready;
        w_pw    = bus.mem_ready;
        if (bus.mem_ready) w_next = DECODE;
      end
      DECODE: begin
        w_src_a = 2'b01;
        w_src_b = 2'b01;
        unique case (1'b1)
          (bus.op == OP_LW),
          (bus.op == OP_SW):  w_next = MEMADR;
          (bus.op == OP_R):   w_next = EXECR;
          (bus.op == OP_I):   w_next = EXECI;
          (bus.op == OP_BEQ): w_next = BEQ;
          (bus.op == OP_JAL): w_next = JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:            w_next = TRAP;
`else
          default:            w_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        w_src_a = 2'b10;
        w_src_b = 2'b01;
        w_next  = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        w_adr = 1'b1;
        if (bus.mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        w_res  = 2'b01;
        w_rw   = 1'b1;
        w_next = FETCH;
      end
      MEMWRITE: begin
        w_adr = 1'b1;
        w_mw  = 1'b1;
        if (bus.mem_ready) w_next = FETCH;
      end
      EXECR: begin
        w_src_a  = 2'b10;
        w_alu_op = 2'b10;
        w_next   = ALUWB;
      end
      EXECI: begin
        w_src_a  = 2'b10;
        w_src_b  = 2'b01;
        w_alu_op = 2'b10;
        w_next   = ALUWB;
      end
      JAL: begin
        w_src_a = 2'b01;
        w_src_b = 2'b10;
        w_pw    = 1'b1;
        w_next  = ALUWB;
      end
      ALUWB: begin
        w_rw   = 1'b1;
        w_next = FETCH;
      end
      BEQ: begin
        w_src_a  = 2'b10;
        w_alu_op = 2'b01;
        w_pw     = bus.zero;
        w_next   = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = FETCH;
    endcase
  end

  // Strobes are masked while reset is held so nothing fires on the reset edge.
  assign bus.ir_write   = w_ir & reset_n;
  assign bus.reg_write  = w_rw & reset_n;
  assign bus.mem_write  = w_mw & reset_n;
  assign bus.pc_write   = w_pw & reset_n;
  assign bus.alu_op     = w_alu_op;
  assign bus.alu_src_a  = w_src_a;
  assign bus.alu_src_b  = w_src_b;
  assign bus.result_src = w_res;
  assign bus.adr_src    = w_adr;
  assign bus.state_dbg  = r_state;

`ifdef ILLEGAL_OP_TRAP_EN
  assign bus.illegal = (r_state == TRAP);
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed scoreboard bench for multicycle_control_fsm.
// Honors ILLEGAL_OP_TRAP_EN for the unknown-opcode scenario.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  multicycle_control_fsm_if #(.STATE_W(4), .OP_W(7)) bus ();

  multicycle_control_fsm #(.STATE_W(4), .OP_W(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aop;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic       adr;
    logic       ir;
    logic       rw;
    logic       mw;
    logic       pw;
    logic       il;
  } exp_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  // strobe vector = {ir_write, reg_write, mem_write, pc_write}
  localparam logic [3:0] NO   = 4'b0000;
  localparam logic [3:0] IRPC = 4'b1001;
  localparam logic [3:0] RWR  = 4'b0100;
  localparam logic [3:0] MWR  = 4'b0010;
  localparam logic [3:0] PCW  = 4'b0001;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  function automatic exp_t mk(logic [3:0] st, logic [3:0] stb, logic il);
    exp_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.sb = 2'b10; e.rs = 2'b10; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  e.adr = 1'b1;
      4'd4:  e.rs = 2'b01;
      4'd5:  e.adr = 1'b1;
      4'd6:  begin e.sa = 2'b10; e.aop = 2'b10; end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
      4'd9:  begin e.sa = 2'b10; e.aop = 2'b01; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; end
      default: ;
    endcase
    {e.ir, e.rw, e.mw, e.pw} = stb;
    e.il = il;
    return e;
  endfunction

  task automatic cyc(input string tag, input logic [6:0] o,
                     input logic mr, input logic z,
                     input logic [3:0] st, input logic [3:0] stb,
                     input logic il);
    exp_t e;
    exp_t obs;
    bus.op = o;
    bus.mem_ready = mr;
    bus.zero = z;
    q.push_back(mk(st, stb, il));
    @(negedge clk);
    e = q.pop_front();
    obs = '{st: bus.state_dbg, aop: bus.alu_op,
            sa: bus.alu_src_a, sb: bus.alu_src_b,
            rs: bus.result_src, adr: bus.adr_src,
            ir: bus.ir_write, rw: bus.reg_write,
            mw: bus.mem_write, pw: bus.pc_write,
            il: bus.illegal};
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op = LW;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst_hold", LW, 1, 0, 4'd0, NO, 0);
    reset_n = 1'b1;

    cyc("lw_fwait", LW, 0, 0, 4'd0, NO, 0);
    cyc("lw_f", LW, 1, 0, 4'd0, IRPC, 0);
    cyc("lw_d", LW, 0, 0, 4'd1, NO, 0);
    cyc("lw_ma", LW, 0, 0, 4'd2, NO, 0);
    cyc("lw_mrwait", LW, 0, 0, 4'd3, NO, 0);
    cyc("lw_mr", LW, 1, 0, 4'd3, NO, 0);
    cyc("lw_wb", LW, 1, 0, 4'd4, RWR, 0);

    cyc("sw_f", SW, 1, 0, 4'd0, IRPC, 0);
    cyc("sw_d", SW, 1, 0, 4'd1, NO, 0);
    cyc("sw_ma", SW, 1, 0, 4'd2, NO, 0);
    for (int i = 0; i < 3; i++)
      cyc("sw_mwwait", SW, 0, 0, 4'd5, MWR, 0);
    cyc("sw_mw", SW, 1, 0, 4'd5, MWR, 0);

    cyc("r_f", RT, 1, 0, 4'd0, IRPC, 0);
    cyc("r_d", RT, 1, 0, 4'd1, NO, 0);
    cyc("r_ex", RT, 1, 0, 4'd6, NO, 0);
    cyc("r_wb", RT, 1, 0, 4'd8, RWR, 0);

    cyc("i_f", IT, 1, 0, 4'd0, IRPC, 0);
    cyc("i_d", IT, 1, 0, 4'd1, NO, 0);
    cyc("i_ex", IT, 1, 0, 4'd7, NO, 0);
    cyc("i_wb", IT, 1, 0, 4'd8, RWR, 0);

    cyc("beq1_f", BQ, 1, 1, 4'd0, IRPC, 0);
    cyc("beq1_d", BQ, 1, 1, 4'd1, NO, 0);
    cyc("beq1_ex", BQ, 1, 1, 4'd9, PCW, 0);
    cyc("beq0_f", BQ, 1, 0, 4'd0, IRPC, 0);
    cyc("beq0_d", BQ, 1, 0, 4'd1, NO, 0);
    cyc("beq0_ex", BQ, 1, 0, 4'd9, NO, 0);

    cyc("jal_f", JL, 1, 0, 4'd0, IRPC, 0);
    cyc("jal_d", JL, 1, 0, 4'd1, NO, 0);
    cyc("jal_ex", JL, 1, 0, 4'd10, PCW, 0);
    cyc("jal_wb", JL, 1, 0, 4'd8, RWR, 0);

    cyc("rsw_f", SW, 1, 0, 4'd0, IRPC, 0);
    cyc("rsw_d", SW, 1, 0, 4'd1, NO, 0);
    cyc("rsw_ma", SW, 1, 0, 4'd2, NO, 0);
    cyc("rsw_mw", SW, 0, 0, 4'd5, MWR, 0);
    reset_n = 1'b0;
    cyc("rst_mid", SW, 1, 0, 4'd0, NO, 0);
    reset_n = 1'b1;
    cyc("rel_f", SW, 1, 0, 4'd0, IRPC, 0);
    cyc("rel_d", SW, 1, 0, 4'd1, NO, 0);
    cyc("rel_ma", SW, 1, 0, 4'd2, NO, 0);
    cyc("rel_mw", SW, 1, 0, 4'd5, MWR, 0);

    cyc("bad_f", BAD, 1, 0, 4'd0, IRPC, 0);
    cyc("bad_d", BAD, 1, 0, 4'd1, NO, 0);
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 10; i++)
      cyc("trap", BAD, i[0], 1, 4'd11, NO, 1);
    reset_n = 1'b0;
    cyc("trap_rst", LW, 1, 0, 4'd0, NO, 0);
    reset_n = 1'b1;
    cyc("trap_rel", LW, 1, 0, 4'd0, IRPC, 0);
`else
    cyc("bad_nop", BAD, 0, 0, 4'd0, NO, 0);
    cyc("bad_next", LW, 1, 0, 4'd0, IRPC, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
